// File: rtl/ccip_rx_poller.sv
// CPU->NIC receive poller: round-robin RDLINE_I reads of per-flow host rings on CCI-P c0,
// forwarding each line whose ownership flag matches the flow's lap parity as one RPC.
module ccip_rx_poller #(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LRX_RING_DEPTH    = 4,
  parameter int RPC_BITS          = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [41:0]                  rx_base_addr,
  input  logic                         start,
  input  logic                         sRx_c0TxAlmFull,
  input  logic                         sRx_c0_rspValid,
  input  logic [3:0]                   sRx_c0_resp_type,
  input  logic [15:0]                  sRx_c0_mdata,
  input  logic [511:0]                 sRx_c0_data,
  output logic                         sTx_c0_valid,
  output logic [1:0]                   sTx_c0_vc_sel,
  output logic [1:0]                   sTx_c0_cl_len,
  output logic [3:0]                   sTx_c0_req_type,
  output logic [41:0]                  sTx_c0_address,
  output logic [15:0]                  sTx_c0_mdata,
  input  logic                         rx_almfull,
  output logic [RPC_BITS-1:0]          rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic                         error,
  output logic [31:0]                  rx_rpc_cnt
);

  localparam int          MAX_RX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
  localparam logic [3:0]  REQ_RDLINE_I = 4'h0;
  localparam logic [3:0]  RSP_RDLINE   = 4'h0;
  localparam logic [1:0]  VC_VH0       = 2'h2;
  localparam logic [1:0]  CL_LEN_1     = 2'h0;

  logic [LMAX_NUM_OF_FLOWS-1:0] poll_flow_reg;
  logic [LRX_RING_DEPTH-1:0]    rd_ptr_reg  [MAX_RX_FLOWS];
  logic                         lap_reg     [MAX_RX_FLOWS];
  logic                         pending_reg [MAX_RX_FLOWS];

  logic                         issue;
  logic                         rsp_valid;
  logic                         rsp_ok;
  logic                         rsp_hit;
  logic [LMAX_NUM_OF_FLOWS-1:0] rsp_flow;
  logic [41:0]                  slot_addr;
  logic                         unused_bits;

  assign unused_bits = ^{sRx_c0_mdata[15:LMAX_NUM_OF_FLOWS], sRx_c0_data[510:RPC_BITS]};

  assign issue     = start && !sRx_c0TxAlmFull && !rx_almfull && !pending_reg[poll_flow_reg];
  assign rsp_valid = sRx_c0_rspValid && (sRx_c0_resp_type == RSP_RDLINE);
  assign rsp_flow  = sRx_c0_mdata[LMAX_NUM_OF_FLOWS-1:0];
  assign rsp_ok    = rsp_valid && pending_reg[rsp_flow];
  assign rsp_hit   = rsp_ok && (sRx_c0_data[511] == lap_reg[rsp_flow]);
  assign slot_addr = rx_base_addr + 42'({poll_flow_reg, rd_ptr_reg[poll_flow_reg]});

  // Issue and response never touch the same flow in one cycle (pending gates both).
  for (genvar gi = 0; gi < MAX_RX_FLOWS; gi++) begin : g_flow
    localparam logic [LMAX_NUM_OF_FLOWS-1:0] FLOW = LMAX_NUM_OF_FLOWS'(gi);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr_reg[gi]  <= '0;
        lap_reg[gi]     <= 1'b1;
        pending_reg[gi] <= 1'b0;
      end else begin
        if (rsp_ok && rsp_flow == FLOW)
          pending_reg[gi] <= 1'b0;
        else if (issue && poll_flow_reg == FLOW)
          pending_reg[gi] <= 1'b1;
        if (rsp_hit && rsp_flow == FLOW) begin
          rd_ptr_reg[gi] <= rd_ptr_reg[gi] + LRX_RING_DEPTH'(1);
          if (rd_ptr_reg[gi] == '1)
            lap_reg[gi] <= ~lap_reg[gi];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_flow_reg   <= '0;
      sTx_c0_valid    <= 1'b0;
      sTx_c0_vc_sel   <= '0;
      sTx_c0_cl_len   <= '0;
      sTx_c0_req_type <= '0;
      sTx_c0_address  <= '0;
      sTx_c0_mdata    <= '0;
      rpc_out         <= '0;
      rpc_out_valid   <= 1'b0;
      rpc_flow_id_out <= '0;
      error           <= 1'b0;
      rx_rpc_cnt      <= '0;
    end else begin
      // A shrunken number_of_flows leaves poll_flow out of range; >= folds it back to 0.
      if (start)
        poll_flow_reg <= (poll_flow_reg >= number_of_flows) ? '0
                         : poll_flow_reg + LMAX_NUM_OF_FLOWS'(1);

      sTx_c0_valid <= issue;
      if (issue) begin
        sTx_c0_vc_sel   <= VC_VH0;
        sTx_c0_cl_len   <= CL_LEN_1;
        sTx_c0_req_type <= REQ_RDLINE_I;
        sTx_c0_address  <= slot_addr;
        sTx_c0_mdata    <= 16'(poll_flow_reg);
      end

      rpc_out_valid <= rsp_hit;
      if (rsp_hit) begin
        rpc_out         <= sRx_c0_data[RPC_BITS-1:0];
        rpc_flow_id_out <= rsp_flow;
        rx_rpc_cnt      <= rx_rpc_cnt + 32'd1;
      end

      if (rsp_valid && !pending_reg[rsp_flow])
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_rx_poller.sv
// Directed bench for ccip_rx_poller: a host-memory responder answers reads (optionally out of
// order) and logs requests and RPCs; one task per scenario compares against hand-derived values.
module tb_ccip_rx_poller;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int RB = 64;
  localparam logic [41:0] BASE = 42'h1000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [L-1:0]   number_of_flows = '0;
  logic [41:0]    rx_base_addr = BASE;
  logic           start = 1'b0;
  logic           sRx_c0TxAlmFull = 1'b0;
  logic           sRx_c0_rspValid = 1'b0;
  logic [3:0]     sRx_c0_resp_type = '0;
  logic [15:0]    sRx_c0_mdata = '0;
  logic [511:0]   sRx_c0_data = '0;
  logic           sTx_c0_valid;
  logic [1:0]     sTx_c0_vc_sel;
  logic [1:0]     sTx_c0_cl_len;
  logic [3:0]     sTx_c0_req_type;
  logic [41:0]    sTx_c0_address;
  logic [15:0]    sTx_c0_mdata;
  logic           rx_almfull = 1'b0;
  logic [RB-1:0]  rpc_out;
  logic           rpc_out_valid;
  logic [L-1:0]   rpc_flow_id_out;
  logic           error;
  logic [31:0]    rx_rpc_cnt;

  ccip_rx_poller #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(L), .LRX_RING_DEPTH(D), .RPC_BITS(RB)) dut (
    .clk(clk), .reset(reset), .number_of_flows(number_of_flows), .rx_base_addr(rx_base_addr),
    .start(start), .sRx_c0TxAlmFull(sRx_c0TxAlmFull), .sRx_c0_rspValid(sRx_c0_rspValid),
    .sRx_c0_resp_type(sRx_c0_resp_type), .sRx_c0_mdata(sRx_c0_mdata), .sRx_c0_data(sRx_c0_data),
    .sTx_c0_valid(sTx_c0_valid), .sTx_c0_vc_sel(sTx_c0_vc_sel), .sTx_c0_cl_len(sTx_c0_cl_len),
    .sTx_c0_req_type(sTx_c0_req_type), .sTx_c0_address(sTx_c0_address),
    .sTx_c0_mdata(sTx_c0_mdata), .rx_almfull(rx_almfull), .rpc_out(rpc_out),
    .rpc_out_valid(rpc_out_valid), .rpc_flow_id_out(rpc_flow_id_out), .error(error),
    .rx_rpc_cnt(rx_rpc_cnt)
  );

  always #5 clk = ~clk;

  // Host memory model: 4 flows x 16 slots starting at BASE.
  logic          mem_flag [64];
  logic [63:0]   mem_pay  [64];
  int            ooo = 0;
  int            base_lat = 4;
  int            clr_req = 0, clr_ack = 0;
  int            inj_req = 0, inj_ack = 0;
  logic [15:0]   inj_mdata = '0;
  logic [3:0]    inj_type = '0;

  typedef struct { logic [41:0] addr; logic [15:0] mdata; int due; } req_t;
  req_t          outq [$];
  logic [41:0]   req_addr_q [$];
  logic [15:0]   req_md_q [$];
  logic [63:0]   rpc_pay_q [$];
  logic [L-1:0]  rpc_flow_q [$];
  int            rpc_total = 0, req_total = 0, lat_bad = 0, cyc = 0;
  logic          prev_valid = 1'b0;
  logic [15:0]   prev_md = '0;

  int checks = 0;
  int passes = 0;

  function automatic logic [63:0] pay_of(int tag, int idx);
    return {24'hC0DE00, 8'(tag), 32'(idx)};
  endfunction

  // Responder/monitor: owns all model queues; runs on the falling edge.
  initial begin
    forever begin
      int hit_i;
      int idx;
      logic [511:0] d;
      @(negedge clk);
      cyc++;
      if (clr_req != clr_ack) begin
        outq.delete(); req_addr_q.delete(); req_md_q.delete();
        rpc_pay_q.delete(); rpc_flow_q.delete();
        rpc_total = 0; req_total = 0; lat_bad = 0;
        clr_ack = clr_req;
      end
      if (rpc_out_valid) begin
        rpc_pay_q.push_back(rpc_out);
        rpc_flow_q.push_back(rpc_flow_id_out);
        rpc_total++;
        if (!(prev_valid && prev_md[L-1:0] == rpc_flow_id_out)) lat_bad++;
      end
      if (sTx_c0_valid) begin
        req_t r;
        int offs [4] = '{5, 0, 3, 1};
        r.addr = sTx_c0_address;
        r.mdata = sTx_c0_mdata;
        r.due = cyc + base_lat + (ooo != 0 ? offs[req_total % 4] : 0);
        req_addr_q.push_back(sTx_c0_address);
        req_md_q.push_back(sTx_c0_mdata);
        outq.push_back(r);
        req_total++;
      end
      sRx_c0_rspValid = 1'b0;
      sRx_c0_resp_type = 4'h0;
      sRx_c0_mdata = '0;
      d = '0;
      if (inj_req != inj_ack) begin
        sRx_c0_rspValid = 1'b1;
        sRx_c0_resp_type = inj_type;
        sRx_c0_mdata = inj_mdata;
        d[511] = 1'b1;
        inj_ack = inj_req;
      end else begin
        hit_i = -1;
        foreach (outq[i]) if (hit_i < 0 && outq[i].due <= cyc) hit_i = i;
        if (hit_i >= 0) begin
          idx = int'(outq[hit_i].addr - BASE) & 63;
          d[511] = mem_flag[idx];
          d[63:0] = mem_pay[idx];
          sRx_c0_rspValid = 1'b1;
          sRx_c0_mdata = outq[hit_i].mdata;
          outq.delete(hit_i);
        end
      end
      sRx_c0_data = d;
      prev_valid = sRx_c0_rspValid && (sRx_c0_resp_type == 4'h0);
      prev_md = sRx_c0_mdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rpcs(int n, int budget);
    int k = 0;
    while (rpc_total < n && k < budget) begin tick(1); k++; end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sRx_c0TxAlmFull = 1'b0; rx_almfull = 1'b0;
    ooo = 0; base_lat = 4; number_of_flows = '0; rx_base_addr = BASE;
    for (int i = 0; i < 64; i++) begin mem_flag[i] = 1'b0; mem_pay[i] = '0; end
    clr_req++;
    tick(2);
    clr_req++;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sTx_c0_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", sTx_c0_valid); else passes++;
    checks++; if (sTx_c0_address !== 42'h0) $display("FAIL rst_addr: got %h want 0", sTx_c0_address); else passes++;
    checks++; if (sTx_c0_vc_sel !== 2'h0) $display("FAIL rst_vc: got %h want 0", sTx_c0_vc_sel); else passes++;
    checks++; if (rpc_out_valid !== 1'b0) $display("FAIL rst_rpc_valid: got %b want 0", rpc_out_valid); else passes++;
    checks++; if (rpc_out !== '0) $display("FAIL rst_rpc_out: got %h want 0", rpc_out); else passes++;
    checks++; if (rpc_flow_id_out !== '0) $display("FAIL rst_flow: got %h want 0", rpc_flow_id_out); else passes++;
    checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passes++;
    checks++; if (rx_rpc_cnt !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", rx_rpc_cnt); else passes++;
  endtask

  task automatic test_single_hit();
    do_reset();
    mem_flag[0] = 1'b1; mem_pay[0] = pay_of(1, 0);
    start = 1'b1;
    wait_rpcs(1, 100);
    checks++; if (req_addr_q.size() == 0 || req_addr_q[0] !== BASE)
      $display("FAIL hit_addr: got %h want %h", req_addr_q.size() ? req_addr_q[0] : 42'h0, BASE); else passes++;
    checks++; if (req_md_q.size() == 0 || req_md_q[0] !== 16'h0)
      $display("FAIL hit_mdata: got %h want 0", req_md_q.size() ? req_md_q[0] : 16'hffff); else passes++;
    checks++; if ({sTx_c0_req_type, sTx_c0_vc_sel, sTx_c0_cl_len} !== {4'h0, 2'h2, 2'h0})
      $display("FAIL hit_hdr: got type %h vc %h len %h want 0/2/0", sTx_c0_req_type, sTx_c0_vc_sel, sTx_c0_cl_len); else passes++;
    checks++; if (rpc_pay_q.size() == 0 || rpc_pay_q[0] !== pay_of(1, 0))
      $display("FAIL hit_payload: got %h want %h", rpc_pay_q.size() ? rpc_pay_q[0] : 64'h0, pay_of(1, 0)); else passes++;
    checks++; if (rpc_flow_q.size() == 0 || rpc_flow_q[0] !== '0)
      $display("FAIL hit_flow: got %h want 0", rpc_flow_q.size() ? rpc_flow_q[0] : 2'h3); else passes++;
    checks++; if (rx_rpc_cnt !== 32'd1) $display("FAIL hit_cnt: got %0d want 1", rx_rpc_cnt); else passes++;
    checks++; if (lat_bad !== 0) $display("FAIL hit_latency: got %0d late RPCs want 0", lat_bad); else passes++;
    tick(20);
    checks++; if (req_addr_q.size() < 2 || req_addr_q[req_addr_q.size()-1] !== BASE + 42'd1)
      $display("FAIL hit_next_slot: got %h want %h", req_addr_q.size() ? req_addr_q[req_addr_q.size()-1] : 42'h0, BASE + 42'd1); else passes++;
    checks++; if (rpc_total !== 1) $display("FAIL hit_single: got %0d RPCs want 1", rpc_total); else passes++;
    start = 1'b0; tick(20);
  endtask

  task automatic test_miss_then_hit();
    int bad = 0;
    do_reset();
    mem_pay[0] = pay_of(2, 0);
    start = 1'b1;
    tick(30);
    checks++; if (rpc_total !== 0) $display("FAIL miss_no_rpc: got %0d want 0", rpc_total); else passes++;
    foreach (req_addr_q[i]) if (req_addr_q[i] !== BASE) bad++;
    checks++; if (req_total < 2 || bad != 0)
      $display("FAIL miss_repoll: got %0d reads, %0d off-slot, want >=2 reads all at %h", req_total, bad, BASE); else passes++;
    mem_flag[0] = 1'b1;
    wait_rpcs(1, 60);
    tick(10);
    checks++; if (rpc_total !== 1) $display("FAIL miss_then_hit_count: got %0d want 1", rpc_total); else passes++;
    checks++; if (rpc_pay_q.size() == 0 || rpc_pay_q[0] !== pay_of(2, 0))
      $display("FAIL miss_then_hit_payload: got %h want %h", rpc_pay_q.size() ? rpc_pay_q[0] : 64'h0, pay_of(2, 0)); else passes++;
    start = 1'b0; tick(20);
  endtask

  task automatic test_wrap_lap();
    int bad = 0;
    int mark;
    do_reset();
    for (int i = 0; i < 16; i++) begin mem_flag[i] = 1'b1; mem_pay[i] = pay_of(1, i); end
    start = 1'b1;
    wait_rpcs(16, 400);
    mark = req_addr_q.size();
    tick(20);
    // Lap is now 0, so the stale flag=1 line at slot 0 must be rejected.
    checks++; if (rpc_total !== 16) $display("FAIL lap_stale: got %0d RPCs want 16", rpc_total); else passes++;
    checks++; if (req_addr_q.size() <= mark || req_addr_q[mark] !== BASE)
      $display("FAIL lap_addr: got %h want %h", req_addr_q.size() > mark ? req_addr_q[mark] : 42'h0, BASE); else passes++;
    for (int i = 0; i < 16; i++) begin mem_flag[i] = 1'b0; mem_pay[i] = pay_of(2, i); end
    wait_rpcs(32, 600);
    checks++; if (rpc_total !== 32) $display("FAIL wrap_count: got %0d want 32", rpc_total); else passes++;
    for (int i = 0; i < rpc_pay_q.size(); i++)
      if (rpc_pay_q[i] !== (i < 16 ? pay_of(1, i) : pay_of(2, i - 16))) bad++;
    checks++; if (bad != 0) $display("FAIL wrap_order: got %0d out-of-order RPCs want 0", bad); else passes++;
    checks++; if (rx_rpc_cnt !== 32'd32) $display("FAIL wrap_cnt: got %0d want 32", rx_rpc_cnt); else passes++;
    start = 1'b0; tick(20);
  endtask

  task automatic test_four_flows();
    int bad = 0;
    int seen [4] = '{0, 0, 0, 0};
    do_reset();
    number_of_flows = 2'd3; ooo = 1;
    for (int f = 0; f < 4; f++)
      for (int s = 0; s < 4; s++) begin mem_flag[f*16+s] = 1'b1; mem_pay[f*16+s] = pay_of(3, f*16+s); end
    start = 1'b1;
    wait_rpcs(16, 600);
    tick(30);
    start = 1'b0;
    tick(40);
    for (int i = 0; i < 4; i++)
      if (req_md_q.size() <= i || req_md_q[i] !== 16'(i) || req_addr_q[i] !== BASE + 42'(16*i)) bad++;
    checks++; if (bad != 0) $display("FAIL rr_issue_order: got %0d wrong of first 4 reads want 0", bad); else passes++;
    bad = 0;
    foreach (req_addr_q[i]) if (req_addr_q[i][5:4] !== req_md_q[i][1:0]) bad++;
    checks++; if (bad != 0) $display("FAIL rr_addr_flow: got %0d mismatched reads want 0", bad); else passes++;
    checks++; if (rpc_total !== 16) $display("FAIL rr_count: got %0d want 16", rpc_total); else passes++;
    bad = 0;
    foreach (rpc_pay_q[i]) begin
      if (rpc_pay_q[i] !== pay_of(3, int'(rpc_flow_q[i])*16 + seen[rpc_flow_q[i]])) bad++;
      seen[rpc_flow_q[i]]++;
    end
    checks++; if (bad != 0) $display("FAIL rr_flow_order: got %0d misordered want 0", bad); else passes++;
    checks++; if (seen[0] != 4 || seen[1] != 4 || seen[2] != 4 || seen[3] != 4)
      $display("FAIL rr_per_flow: got %0d/%0d/%0d/%0d want 4 each", seen[0], seen[1], seen[2], seen[3]); else passes++;
    checks++; if (lat_bad !== 0) $display("FAIL rr_latency: got %0d late RPCs want 0", lat_bad); else passes++;
  endtask

  task automatic test_backpressure();
    int b_req, b_rpc, bad;
    int seen [4] = '{0, 0, 0, 0};
    do_reset();
    number_of_flows = 2'd3; ooo = 1; base_lat = 8;
    for (int i = 0; i < 64; i++) begin mem_flag[i] = 1'b1; mem_pay[i] = pay_of(4, i); end
    start = 1'b1;
    tick(12);
    sRx_c0TxAlmFull = 1'b1;
    tick(1); b_req = req_total; b_rpc = rpc_total;
    tick(9);
    checks++; if (req_total != b_req) $display("FAIL bp_almfull_reads: got %0d reads want 0", req_total - b_req); else passes++;
    checks++; if (rpc_total <= b_rpc) $display("FAIL bp_almfull_inflight: got %0d RPCs want >0", rpc_total - b_rpc); else passes++;
    sRx_c0TxAlmFull = 1'b0;
    tick(10);
    checks++; if (req_total <= b_req) $display("FAIL bp_resume: got %0d reads want >0", req_total - b_req); else passes++;
    rx_almfull = 1'b1;
    tick(1); b_req = req_total; b_rpc = rpc_total;
    tick(9);
    checks++; if (req_total != b_req) $display("FAIL bp_rxalm_reads: got %0d reads want 0", req_total - b_req); else passes++;
    checks++; if (rpc_total <= b_rpc) $display("FAIL bp_rxalm_inflight: got %0d RPCs want >0", rpc_total - b_rpc); else passes++;
    rx_almfull = 1'b0;
    tick(10);
    start = 1'b0;
    tick(60);
    checks++; if (rx_rpc_cnt !== 32'(rpc_total)) $display("FAIL bp_cnt: got %0d want %0d", rx_rpc_cnt, rpc_total); else passes++;
    bad = 0;
    foreach (rpc_pay_q[i]) begin
      if (rpc_pay_q[i] !== pay_of(4, int'(rpc_flow_q[i])*16 + seen[rpc_flow_q[i]])) bad++;
      seen[rpc_flow_q[i]]++;
    end
    checks++; if (bad != 0 || lat_bad != 0) $display("FAIL bp_order: got %0d misordered %0d late want 0", bad, lat_bad); else passes++;
  endtask

  task automatic test_error_and_reset();
    do_reset();
    number_of_flows = 2'd3;
    inj_type = 4'h4; inj_mdata = 16'd1; inj_req++;
    tick(2);
    checks++; if (error !== 1'b0) $display("FAIL err_other_type: got %b want 0", error); else passes++;
    inj_type = 4'h0; inj_mdata = 16'd2; inj_req++;
    tick(2);
    checks++; if (error !== 1'b1) $display("FAIL err_set: got %b want 1", error); else passes++;
    checks++; if (rx_rpc_cnt !== 32'd0) $display("FAIL err_no_rpc: got %0d want 0", rx_rpc_cnt); else passes++;
    tick(5);
    checks++; if (error !== 1'b1) $display("FAIL err_sticky: got %b want 1", error); else passes++;
    for (int i = 0; i < 64; i++) begin mem_flag[i] = 1'b1; mem_pay[i] = pay_of(5, i); end
    start = 1'b1;
    tick(15);
    checks++; if (rx_rpc_cnt === 32'd0) $display("FAIL pre_reset_traffic: got 0 RPCs want >0"); else passes++;
    reset = 1'b1;
    clr_req++;
    #2;
    checks++; if ({sTx_c0_valid, sTx_c0_address, sTx_c0_mdata} !== '0)
      $display("FAIL arst_tx: got valid %b addr %h mdata %h want 0", sTx_c0_valid, sTx_c0_address, sTx_c0_mdata); else passes++;
    checks++; if ({rpc_out_valid, rpc_out, rpc_flow_id_out} !== '0)
      $display("FAIL arst_rpc: got valid %b out %h flow %h want 0", rpc_out_valid, rpc_out, rpc_flow_id_out); else passes++;
    checks++; if (error !== 1'b0) $display("FAIL arst_error: got %b want 0", error); else passes++;
    checks++; if (rx_rpc_cnt !== 32'd0) $display("FAIL arst_cnt: got %0d want 0", rx_rpc_cnt); else passes++;
    tick(2);
    clr_req++;
    reset = 1'b0;
    tick(3);
    checks++; if (req_addr_q.size() == 0 || req_addr_q[0] !== BASE || req_md_q[0] !== 16'h0)
      $display("FAIL post_reset_first_read: got %h want %h", req_addr_q.size() ? req_addr_q[0] : 42'h0, BASE); else passes++;
    start = 1'b0;
    tick(40);
    checks++; if (error !== 1'b0) $display("FAIL post_reset_error: got %b want 0", error); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss_then_hit();
    test_wrap_lap();
    test_four_flows();
    test_backpressure();
    test_error_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ccip_rx_poller.md
# ccip_rx_poller

CPU→NIC receive path of the CCI-P CPU-NIC interface: polls per-flow ring buffers in host memory with eREQ_RDLINE_I reads on CCI-P channel 0. Each returned line whose ownership flag matches the flow's expected lap parity is forwarded as one RPC to the NIC core. Non-matching lines are discarded. Sits beside ccip_transmitter: the transmitter writes NIC→CPU lines, this block reads CPU→NIC lines.

## Interface
- NIC_ID, 0, NIC identifier (simulation messages only)
- LMAX_NUM_OF_FLOWS, 1, log2 of maximum number of flows; MAX_RX_FLOWS = 2**LMAX_NUM_OF_FLOWS
- LRX_RING_DEPTH, 4, log2 of cache-line slots per flow ring

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest active flow index (number of active flows minus 1)
- rx_base_addr  in  t_ccip_clAddr  cache-line address of flow 0, slot 0
- start  in  1  enables polling; when low, no new reads are issued, but responses are still processed
- sRx_c0TxAlmFull  in  1  CCI-P c0 TX almost-full; when high, no read is issued
- sRx_c0  in  t_if_ccip_c0_Rx  CCI-P read responses
- sTx_c0  out  t_if_ccip_c0_Tx  CCI-P read requests
- rx_almfull  in  1  downstream RPC FIFO almost-full; when high, no read is issued. Downstream guarantees ≥ MAX_RX_FLOWS entries of headroom at assertion.
- rpc_out  out  RpcIf  received RPC
- rpc_out_valid  out  1  one-cycle strobe per RPC; no ready signal, downstream must accept
- rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow of rpc_out
- error  out  1  sticky; a response was received for a flow with no outstanding read
- rx_rpc_cnt  out  32  total RPCs delivered; wraps mod 2^32

## Operation
- Ring layout:
  - Slot address = rx_base_addr + {flow, rd_ptr[flow]} (flow in the upper LMAX_NUM_OF_FLOWS bits, slot in the lower LRX_RING_DEPTH bits).
  - Ownership flag = data[511].
  - Payload = data[$bits(RpcIf)-1:0].
- Per-flow state:
  - rd_ptr: LRX_RING_DEPTH bits, reset 0.
  - lap: 1 bit, reset 1. Host memory is zero-initialised, and the host writes flag=1 on the first lap.
  - pending: 1 bit, reset 0.
- At most one outstanding read per flow. This preserves in-order delivery within a flow.
- Poll scheduler (round-robin pointer poll_flow, reset 0), evaluated every cycle:
  - Issue condition: start && !sRx_c0TxAlmFull && !rx_almfull && !pending[poll_flow].
  - If the issue condition holds, register a read request:
    - hdr = 0 except req_type=eREQ_RDLINE_I, vc_sel=eVC_VH0, cl_len=eCL_LEN_1, address = slot address, mdata = zero-extended poll_flow.
    - Set pending[poll_flow].
  - poll_flow advances every cycle while start is high, whether or not a read was issued.
  - poll_flow wraps to 0 after number_of_flows. If poll_flow > number_of_flows (the register was lowered while running), it wraps to 0 on the next step.
- Response handling. A response is sRx_c0.rspValid && hdr.resp_type == eRSP_RDLINE; it applies to flow f = hdr.mdata[LMAX_NUM_OF_FLOWS-1:0].
  - If pending[f] == 0: set error, otherwise ignore the response.
  - Else clear pending[f].
  - Hit (flag == lap[f]):
    - Register rpc_out = payload, rpc_flow_id_out = f, pulse rpc_out_valid.
    - Increment rd_ptr[f] and rx_rpc_cnt.
    - On rd_ptr wrap from 2^LRX_RING_DEPTH-1 to 0, toggle lap[f].
  - Miss (flag != lap[f]): no output; re-poll the same slot on the next scheduler visit.
  - Other response types are ignored.
- Same-cycle issue and response:
  - Different flows: both take effect.
  - Same flow: impossible, because issue requires !pending and a response requires pending. The issue decision uses the pre-clear value, so that flow is re-issued no earlier than its next scheduler visit.
- Deasserting start stops new issues. Outstanding responses still complete and deliver RPCs.

## Timing
- Read request: sTx_c0.valid is registered, asserted the cycle after the issue condition is sampled.
- Response to output: rpc_out_valid asserts the cycle after rspValid (1-cycle latency), back-to-back capable.
- Maximum read rate: one read per cycle. Per-flow re-poll interval ≥ number_of_flows+1 cycles and ≥ memory round trip.
- sRx_c0TxAlmFull or rx_almfull sampled high: no valid on sTx_c0 in the following cycle. Reads already issued are not cancelled.
- Reset values:
  - sTx_c0.valid=0, sTx_c0.hdr=0.
  - rpc_out_valid=0, rpc_out=0, rpc_flow_id_out=0.
  - error=0, rx_rpc_cnt=0.
  - All rd_ptr=0, lap=1, pending=0, poll_flow=0.
- Reset asserted mid-operation clears all state asynchronously. Responses arriving after reset release hit pending=0 and set error; software resets the host side together with this block.

## Test plan
- Single hit:
  - Setup: number_of_flows=0, LRX_RING_DEPTH=4, base=0x1000, slot0 flag=1, payload P0.
  - Stimulus: start.
  - Required response: read at 0x1000 with mdata=0; one cycle after the response, rpc_out=P0, flow 0; rd_ptr=1; rx_rpc_cnt=1.
- Miss then hit:
  - Setup: slot0 flag=0.
  - Required response: no rpc_out_valid; re-read of 0x1000. After the host sets flag=1, exactly one RPC is delivered.
- Wrap and lap:
  - Stimulus: host fills 16 slots with flag=1, then 16 slots with flag=0.
  - Required response: 32 RPCs in slot order; lap toggles to 0 after slot 15; the second-lap address returns to 0x1000.
- Four flows round-robin:
  - Setup: number_of_flows=3; all flows have data.
  - Required response: issue order flows 0,1,2,3,0…; flow-f addresses = 0x1000+16f+rd_ptr; per-flow order preserved with out-of-order memory responses.
- Backpressure:
  - Stimulus: sRx_c0TxAlmFull=1 for 10 cycles, then rx_almfull=1 for 10 cycles.
  - Required response: zero reads issued one cycle after each assertion; in-flight responses still produce RPCs.
- Error and reset:
  - Stimulus: inject an eRSP_RDLINE response with mdata=2 while pending[2]=0.
  - Required response: error=1 and stays 1.
  - Stimulus: reset mid-stream.
  - Required response: all outputs at reset values on the same edge; error=0.
